ascon_loader: RTL
=================

ASCON_LOADER -- requirements
Module: ascon_loader

Interface
REQ-001 SHALL: clk  input  1  single clock; all flops on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_data  input  8  byte-serial command/payload stream.
REQ-004 SHALL: in_valid  input  1  in_data valid this cycle.
REQ-005 SHALL: in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL: reg0_128b, reg1_128b, reg2_128b  output  128 each  operand registers feeding the Ascon core (key/nonce/data).
REQ-007 SHALL: operation_mode  output  3  latched mode for the core: 0 idle, 1 encrypt, 2 decrypt, 3 hash, 4 XOF, 5 CXOF.
REQ-008 SHALL: operation_ready  output  1  one-cycle start pulse to the core.
REQ-009 SHALL: err  output  1  sticky protocol-error flag.

Function
REQ-010 SHALL: header byte fields are opcode in_data[7:6] (00 load, 01 start, 10 clear, 11 reserved), register select in_data[5:4], and mode in_data[2:0]; in_data[3] is ignored.
REQ-011 SHALL: the FSM has three states: HEADER, PAYLOAD and START; the reset state is HEADER.
REQ-012 SHALL: in_ready is 1 in HEADER and PAYLOAD, and 0 in START.
REQ-013 SHALL: a load header with select 0..2 latches the select, clears the 4-bit byte counter, and moves to PAYLOAD.
REQ-014 SHALL: a load header with select 3 sets err, is consumed, and stays in HEADER.
REQ-015 SHALL: in PAYLOAD, each accepted byte shifts into a 128-bit shift register MSB-first (first byte lands in [127:120]) and increments the counter.
REQ-016 SHALL: the 16th payload byte (counter 15) copies the completed shift value into the selected register at that same edge, wraps the counter to 0, and returns to HEADER.
REQ-017 SHALL: the reg outputs never show partial payload; in_valid low in PAYLOAD holds all state indefinitely (no timeout).
REQ-018 SHALL: a start header with mode 0..5 latches operation_mode and moves to START; operation_ready is 1 exactly in the START cycle, followed by an unconditional return to HEADER.
REQ-019 SHALL: a start header with mode 6 or 7 sets err, leaves operation_mode unchanged, emits no pulse, and stays in HEADER.
REQ-020 SHALL: a reserved opcode (11) sets err and stays in HEADER.
REQ-021 SHALL: operation_mode and reg0..2 remain stable from the START cycle until the next accepted load or start, so the core may sample them at any time during its run.
REQ-022 SHALL: the loader has no back-pressure from the core; the sender is responsible for not issuing start while the core is running.

Reset
REQ-023 SHALL: while rst_n is low, state=HEADER, counter=0, shift register and reg0..2 = 0, operation_mode=0, operation_ready=0 and err=0; the outputs respond asynchronously.
REQ-024 SHALL: reset during PAYLOAD discards the partial payload; the first byte after release is treated as a header.

Configuration
REQ-025 SHALL: with ASCON_LOADER_CLEAR_EN defined, an accepted clear header zeroes reg0..2, operation_mode and err at that edge and stays in HEADER.
REQ-026 SHALL: without ASCON_LOADER_CLEAR_EN, opcode 10 is treated as reserved per REQ-020, and err is cleared only by reset.

Verification
REQ-027 SHALL: header 0x00 followed by bytes 0x00..0x0F -> reg0_128b=0x000102030405060708090A0B0C0D0E0F on the 16th-byte edge, with reg1/reg2 unchanged.
REQ-028 SHALL: header 0x41 -> operation_mode=1, operation_ready high for exactly 1 cycle, and in_ready low in that same cycle.
REQ-029 SHALL: header 0x30 -> err=1, next byte 0x10 accepted as a load of reg1 (no payload consumed by the bad header).
REQ-030 SHALL: header 0x20, 8 payload bytes, rst_n low for 1 cycle, then header 0x20 and 16 bytes of 0xAA -> reg2_128b is all 0xAA with no leftover bytes.
REQ-031 SHALL: header 0x47 -> err=1, no operation_ready pulse, operation_mode retains its prior value.
REQ-032 SHALL: with ASCON_LOADER_CLEAR_EN, header 0x80 after loads and an error -> reg0..2=0, operation_mode=0, err=0; without the macro, the same header sets err=1 and registers are unchanged.

Source files
------------

// File: rtl/ascon_loader_if.sv
// ascon_loader_if -- byte-serial valid/ready stream carrying loader commands
// and payload bytes.
//   in_data  : 8-bit header or payload byte (sender -> loader)
//   in_valid : in_data is valid this cycle (sender -> loader)
//   in_ready : loader can accept a byte (loader -> sender)
// A byte is transferred on a rising clock edge where in_valid and in_ready
// are both high.
interface ascon_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ascon_loader.sv
// ascon_loader -- command/payload loader for an Ascon core.
// A byte stream of headers and payloads fills three 128-bit operand
// registers and launches the core with a one-cycle start pulse.
//
// Ports:
//   clk             : single clock, rising edge
//   rst_n           : asynchronous active-low reset
//   bus             : ascon_loader_if.slave (in_data / in_valid / in_ready)
//   reg0_128b..2    : operand registers (key / nonce / data)
//   operation_mode  : latched mode (0 idle,1 enc,2 dec,3 hash,4 XOF,5 CXOF)
//   operation_ready : one-cycle start pulse to the core
//   err             : sticky protocol-error flag
//
// Header byte: [7:6] opcode (00 load, 01 start, 10 clear, 11 reserved),
//              [5:4] register select, [3] ignored, [2:0] mode.
//
// Optional feature: define ASCON_LOADER_CLEAR_EN to make opcode 10 zero the
// operand registers, operation_mode and err. Without it, opcode 10 is
// reserved and err is cleared only by reset.
module ascon_loader (
  input  logic              clk,
  input  logic              rst_n,
  ascon_loader_if.slave     bus,
  output logic [127:0]      reg0_128b,
  output logic [127:0]      reg1_128b,
  output logic [127:0]      reg2_128b,
  output logic [2:0]        operation_mode,
  output logic              operation_ready,
  output logic              err
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    START   = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   byte_cnt;
  logic [1:0]   sel_q;
  logic [127:0] shift_q;

  logic         accept;
  logic [1:0]   hdr_op;
  logic [1:0]   hdr_sel;
  logic [2:0]   hdr_mode;
  logic [127:0] shift_next;

  // in_ready is a pure decode of the state flop; the loader only refuses
  // bytes during the single START cycle.
  assign bus.in_ready = (state != START);
  assign accept       = bus.in_valid && bus.in_ready;

  assign hdr_op     = bus.in_data[7:6];
  assign hdr_sel    = bus.in_data[5:4];
  assign hdr_mode   = bus.in_data[2:0];
  // MSB-first: the first payload byte ends up in [127:120] after 16 shifts.
  assign shift_next = {shift_q[119:0], bus.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HEADER;
      byte_cnt        <= 4'd0;
      sel_q           <= 2'd0;
      shift_q         <= '0;
      reg0_128b       <= '0;
      reg1_128b       <= '0;
      reg2_128b       <= '0;
      operation_mode  <= 3'd0;
      operation_ready <= 1'b0;
      err             <= 1'b0;
    end else begin
      operation_ready <= 1'b0;
      case (state)
        HEADER: begin
          if (accept) begin
            case (hdr_op)
              OP_LOAD: begin
                if (hdr_sel != 2'd3) begin
                  sel_q    <= hdr_sel;
                  byte_cnt <= 4'd0;
                  state    <= PAYLOAD;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_START: begin
                if (hdr_mode <= 3'd5) begin
                  operation_mode  <= hdr_mode;
                  operation_ready <= 1'b1;
                  state           <= START;
                end else begin
                  err <= 1'b1;
                end
              end
`ifdef ASCON_LOADER_CLEAR_EN
              OP_CLEAR: begin
                reg0_128b      <= '0;
                reg1_128b      <= '0;
                reg2_128b      <= '0;
                operation_mode <= 3'd0;
                err            <= 1'b0;
              end
`else
              OP_CLEAR: begin
                err <= 1'b1;
              end
`endif
              default: begin
                err <= 1'b1;
              end
            endcase
          end
        end

        PAYLOAD: begin
          if (accept) begin
            shift_q  <= shift_next;
            byte_cnt <= byte_cnt + 4'd1;
            // Operand registers update only when all 16 bytes are in, so the
            // core never sees a partially loaded value.
            if (byte_cnt == 4'd15) begin
              case (sel_q)
                2'd0:    reg0_128b <= shift_next;
                2'd1:    reg1_128b <= shift_next;
                default: reg2_128b <= shift_next;
              endcase
              state <= HEADER;
            end
          end
        end

        START: begin
          state <= HEADER;
        end

        default: begin
          state <= HEADER;
        end
      endcase
    end
  end

endmodule
